// File: rtl/branch_pkg.sv
// branch_pkg
// Shared definitions for the branch-decision unit and the instruction decoder
// that drives it: the 3-bit branch opcode encoding and the controller states.
package branch_pkg;

  localparam int BR_OP_W = 3;

  // Opcode encoding is shared with the decoder; values are fixed.
  typedef enum logic [BR_OP_W-1:0] {
    OP_NOP  = 3'd0,
    OP_JMP  = 3'd1,
    OP_BZ   = 3'd2,
    OP_BNZ  = 3'd3,
    OP_BN   = 3'd4,
    OP_CALL = 3'd5,
    OP_RET  = 3'd6,
    OP_HALT = 3'd7
  } br_op_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } bc_state_t;

endpackage

// File: rtl/ret_stack.sv
// ret_stack
// Small LIFO of return addresses for CALL/RET.
// Ports:
//   clk, reset      clock, synchronous active-high reset (clears the pointer)
//   push, pop       push/pop strobes; ignored when full/empty respectively
//   push_data [D]   address pushed on a push
//   top [D]         current top entry (0 when empty)
//   full, empty     occupancy flags
// The owner never asserts push and pop in the same cycle.
module ret_stack #(
  parameter int D        = 8,
  parameter int RS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] push_data,
  output logic [D-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(RS_DEPTH + 1);
  localparam int IW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  logic [D-1:0]  mem [RS_DEPTH];
  logic [PW-1:0] ptr;      // number of valid entries
  logic [PW-1:0] top_ptr;

  assign full    = (ptr == PW'(RS_DEPTH));
  assign empty   = (ptr == '0);
  assign top_ptr = ptr - PW'(1);
  assign top     = empty ? '0 : mem[top_ptr[IW-1:0]];

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + PW'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - PW'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; clearing the pointer
  // makes every entry invalid, and leaving the array out of reset lets it map
  // onto plain RAM/flops without a reset fan-out.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[ptr[IW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl
// Branch-decision unit on the driving side of the program counter. Produces
// the branch/target pair the PC samples at the next edge, and owns the flag
// register, the absolute-target LUT, the return stack and the HALT state.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   prog_ctr [D]          current PC
//   instr_valid           br_op/br_idx meaningful this cycle
//   br_op [3], br_idx     branch opcode and LUT index
//   flag_we, zero_in, neg_in          flag register load
//   lut_we, lut_waddr, lut_wdata      LUT write port
//   branch, target [D]    combinational decision for this cycle
//   halted                controller is in HALTED
//   rs_err                sticky return-stack overflow/underflow
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int D         = 8,
  parameter int LUT_DEPTH = 16,
  parameter int RS_DEPTH  = 4,
  parameter int LW        = $clog2(LUT_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [D-1:0]  prog_ctr,
  input  logic          instr_valid,
  input  logic [2:0]    br_op,
  input  logic [LW-1:0] br_idx,
  input  logic          flag_we,
  input  logic          zero_in,
  input  logic          neg_in,
  input  logic          lut_we,
  input  logic [LW-1:0] lut_waddr,
  input  logic [D-1:0]  lut_wdata,
  output logic          branch,
  output logic [D-1:0]  target,
  output logic          halted,
  output logic          rs_err
);

  bc_state_t    state, state_next;
  br_op_t       op;
  logic         z_flag, n_flag;
  logic [D-1:0] lut [LUT_DEPTH];
  logic [D-1:0] lut_rd;
  logic         rs_push, rs_pop, rs_full, rs_empty, err_set;
  logic [D-1:0] rs_top;

  assign op     = br_op_t'(br_op);
  assign lut_rd = lut[br_idx];   // reads pre-write contents on a same-index write
  assign halted = (state == HALTED);

  ret_stack #(.D(D), .RS_DEPTH(RS_DEPTH)) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (rs_push),
    .pop       (rs_pop),
    .push_data (prog_ctr + D'(1)),   // wraps mod 2^D
    .top       (rs_top),
    .full      (rs_full),
    .empty     (rs_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Next-state logic: HALTED is left only through reset.
  always_comb begin
    state_next = state;
    if (state == RUN && instr_valid && op == OP_HALT) state_next = HALTED;
  end

  // Output / decision logic.
  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    branch  = 1'b0;
    target  = '0;
    rs_push = 1'b0;
    rs_pop  = 1'b0;
    err_set = 1'b0;
    if (reset) begin
      // Outputs forced low; gating the push here also discards a CALL.
    end else if (state == HALTED) begin
      branch = 1'b1;
      target = prog_ctr;
    end else if (instr_valid) begin
      unique case (op)
        OP_NOP: ;
        OP_JMP: begin
          branch = 1'b1;
          target = lut_rd;
        end
        OP_BZ, OP_BNZ, OP_BN: begin
          // Uses the registered flags; a same-cycle flag_we is not bypassed.
          branch = (op == OP_BZ)  ?  z_flag :
                   (op == OP_BNZ) ? !z_flag : n_flag;
          target = branch ? lut_rd : '0;
        end
        OP_CALL: begin
          if (rs_full) begin
            err_set = 1'b1;
          end else begin
            branch  = 1'b1;
            target  = lut_rd;
            rs_push = 1'b1;
          end
        end
        OP_RET: begin
          if (rs_empty) begin
            err_set = 1'b1;
          end else begin
            branch = 1'b1;
            target = rs_top;
            rs_pop = 1'b1;
          end
        end
        OP_HALT: begin
          branch = 1'b1;
          target = prog_ctr;
        end
        default: ;
      endcase
    end
  end

  // Flags, LUT and error flag keep updating in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      z_flag <= 1'b0;
      n_flag <= 1'b0;
      rs_err <= 1'b0;
    end else begin
      if (flag_we) begin
        z_flag <= zero_in;
        n_flag <= neg_in;
      end
      if (err_set) rs_err <= 1'b1;
    end
  end

  // LUT contents are architecturally visible after reset, so they are cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut[i] <= '0;
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch-decision unit sitting on the driving side of the program counter: it consumes the current `prog_ctr` and decoded branch fields, and produces the `branch`/`target` pair the PC samples on the next clock edge. It owns the condition-flag register, a writable absolute-target lookup table, a small return-address stack for CALL/RET, and the HALT state that freezes the PC.

## Interface
- `D`, 8, program-counter width.
- `LUT_DEPTH`, 16, number of absolute-target entries; index width `LW = $clog2(LUT_DEPTH)`.
- `RS_DEPTH`, 4, return-stack entries; pointer width `$clog2(RS_DEPTH+1)`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `prog_ctr`  in  D  current PC value.
- `instr_valid`  in  1  `br_op`/`br_idx` are meaningful this cycle.
- `br_op`  in  3  branch opcode (`br_op_t`).
- `br_idx`  in  LW  LUT index for JMP/BZ/BNZ/BN/CALL.
- `flag_we`  in  1  load `zero_in`/`neg_in` into the flag register.
- `zero_in`, `neg_in`  in  1 each  ALU flags.
- `lut_we`  in  1  LUT write enable.
- `lut_waddr`  in  LW  LUT write index.
- `lut_wdata`  in  D  LUT write data.
- `branch`  out  1  PC loads `target` at the next edge.
- `target`  out  D  jump destination.
- `halted`  out  1  FSM is in HALTED.
- `rs_err`  out  1  sticky stack overflow/underflow.

## Operation
- Opcodes: 0 NOP, 1 JMP, 2 BZ, 3 BNZ, 4 BN, 5 CALL, 6 RET, 7 HALT.
- FSM: RUN, HALTED. RUN→HALTED on a valid HALT. HALTED exits only via `reset`.
- In RUN, with `instr_valid`=1:
  - JMP: take, `target`=`lut[br_idx]`.
  - BZ/BNZ/BN: take if Z=1 / Z=0 / N=1, `target`=`lut[br_idx]`.
  - CALL: if the stack is not full, take, `target`=`lut[br_idx]`, and push `prog_ctr+1` (mod 2^D, so 0xFF pushes 0x00). If the stack is full, do not take, do not push, and set `rs_err`.
  - RET: if the stack is not empty, take, `target`=top, and pop. If empty, do not take and set `rs_err`.
  - HALT: take, `target`=`prog_ctr`.
  - NOP: not taken.
- `instr_valid`=0: not taken, no stack or FSM change. Flag and LUT writes still apply.
- HALTED: `branch`=1, `target`=`prog_ctr` every cycle regardless of inputs. No pushes or pops. Flag and LUT writes still apply.
- Not taken: `target`=0.
- Flags are registered. A branch in the same cycle as `flag_we` uses the old flags; there is no bypass.
- A LUT read and write to the same index in one cycle: the read returns the old value.
- `rs_err` is sticky until reset.

## Timing
- `branch`/`target` are combinational from the inputs and registered state in the same cycle. The PC consumes them at the following posedge, so there is zero added latency.
- Flags, LUT, stack, pointer, FSM and `rs_err` update at posedge.
- Reset values (registers written on a `reset` edge):
  - Flags = 0, all LUT entries = 0, stack pointer = 0, FSM = RUN, `rs_err`=0, `halted`=0.
- While `reset` is high, `branch` is forced to 0 and `target` to 0 combinationally.
- `reset` has priority over `lut_we`, `flag_we` and any op in the same cycle.
- Reset mid-CALL: the push is discarded.

## Structure
- `branch_pkg`: `br_op_t` enum (3-bit), `bc_state_t` enum {RUN, HALTED}, and opcode constants shared with the decoder.
- Sub-module `ret_stack` (parameters `D`, `RS_DEPTH`):
  - Inputs: push, pop, push data.
  - Outputs: top, full, empty.
  - Synchronous reset clears the pointer.
  - `branch_ctrl` never asserts push and pop together.

## Test plan
- Reset, then write `lut[3]`=0x40 and issue JMP idx 3 at PC 0x10 → `branch`=1, `target`=0x40.
- Flag forwarding: with `flag_we`=1, `zero_in`=1 issue BZ idx 3 in the same cycle → not taken. Repeat BZ next cycle → taken, `target`=0x40.
- Call/return: write `lut[1]`=0x80. CALL idx 1 at PC 0x05 → `target`=0x80. Later RET → `target`=0x06. CALL at PC 0xFF → a later RET gives `target`=0x00.
- Stack limits:
  - Five CALLs with `RS_DEPTH`=4: the fifth is not taken and `rs_err`=1.
  - After reset, RET on an empty stack: not taken, `rs_err`=1.
- HALT at PC 0x22 → `halted`=1, `branch`=1, `target`=0x22 every cycle, even with JMP presented. Assert `reset` → `halted`=0, `branch`=0.
- LUT same-cycle: `lut[2]`=0x11, then write 0x99 to index 2 while issuing JMP idx 2 → `target`=0x11. Next cycle JMP idx 2 → `target`=0x99.
